// File: rtl/hello_seq_ctrl_pkg.sv
// hello_seq_ctrl_pkg: shared state encoding and default sizes for the hello sequencer
package hello_seq_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_DONE = 2'd2} state_t;
  localparam int N_BITS_DEF = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/hello_hold_timer.sv
// hello_hold_timer: per-bit hold counter with clear/enable and a last-cycle flag
module hello_hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] hold,
  output logic             last
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign last = cnt == hold - 1'b1;
endmodule

// File: rtl/hello_seq_ctrl.sv
// hello_seq_ctrl: drives a stored pattern into the hello unit and checks its response
module hello_seq_ctrl
  import hello_seq_ctrl_pkg::*;
#(
  parameter int N_BITS   = N_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ERR_W    = 3,
  parameter bit INVERT   = 1'b0,
  parameter bit IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [N_BITS-1:0] pattern,
  input  logic [CNT_W-1:0]  hold_cycles,
  output logic              drive_a,
  input  logic              resp_b,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              pass
);
  localparam int IDX_W = N_BITS > 1 ? $clog2(N_BITS) : 1;
  state_t state, state_nx;
  logic [N_BITS-1:0] pat;
  logic [CNT_W-1:0] hold;
  logic [IDX_W-1:0] idx;
  logic last, last_bit, miss;
  logic [ERR_W-1:0] err_nx;
  assign last_bit = idx == IDX_W'(N_BITS - 1);
  assign miss = resp_b != (pat[idx] ^ INVERT);
  assign err_nx = (miss && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == S_IDLE  ? (start ? S_DRIVE : S_IDLE) :
               state == S_DRIVE ? ((abort || (last && last_bit)) ? S_DONE : S_DRIVE) :
                                  S_IDLE;
    busy = state == S_DRIVE;
    done = state == S_DONE;
    drive_a = busy ? pat[idx] : IDLE_LVL;
  end
  // abort takes priority over the sample that would land on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pat <= '0;
      hold <= '0;
      idx <= '0;
      err_cnt <= '0;
      pass <= 1'b0;
    end else if (state == S_IDLE && start) begin
      pat <= pattern;
      hold <= hold_cycles == '0 ? CNT_W'(1) : hold_cycles;
      idx <= '0;
      err_cnt <= '0;
      pass <= 1'b0;
    end else if (state == S_DRIVE) begin
      if (abort) pass <= 1'b0;
      else if (last) begin
        err_cnt <= err_nx;
        idx <= idx + 1'b1;
        if (last_bit) pass <= err_nx == '0;
      end
    end
  hello_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != S_DRIVE || last),
    .en   (busy),
    .hold (hold),
    .last (last)
  );
endmodule

// File: tb/tb_hello_seq_ctrl.sv
// tb_hello_seq_ctrl: scoreboard bench for buffer and inverting hello configurations
module tb_hello_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, force0 = 1'b0, sel = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] hold_cycles = '0;
  logic a0, a1, b0, b1, busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] err0, err1;
  int checks = 0, failures = 0;
  logic exp_a_q[$];
  logic [3:0] exp_r_q[$];
  assign b0 = force0 ? 1'b0 : a0;
  assign b1 = ~a1;
  wire ma = sel ? a1 : a0;
  wire mb = sel ? busy1 : busy0;
  wire md = sel ? done1 : done0;
  wire mp = sel ? pass1 : pass0;
  wire [2:0] me = sel ? err1 : err0;
  always #5 clk = ~clk;
  hello_seq_ctrl #(.N_BITS(4), .CNT_W(8), .ERR_W(3), .INVERT(1'b0), .IDLE_LVL(1'b0)) u_buf (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
    .hold_cycles(hold_cycles), .drive_a(a0), .resp_b(b0), .busy(busy0), .done(done0),
    .err_cnt(err0), .pass(pass0));
  hello_seq_ctrl #(.N_BITS(4), .CNT_W(8), .ERR_W(3), .INVERT(1'b1), .IDLE_LVL(1'b0)) u_inv (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
    .hold_cycles(hold_cycles), .drive_a(a1), .resp_b(b1), .busy(busy1), .done(done1),
    .err_cnt(err1), .pass(pass1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_drive_a"}, ma, 0);
    check({tag, "_busy"}, mb, 0);
    check({tag, "_done"}, md, 0);
    check({tag, "_err"}, me, 0);
    check({tag, "_pass"}, mp, 0);
  endtask
  task automatic run(input logic [3:0] p, input int h, input int abort_at, input bit midstart);
    int hh, nb, blen, e;
    logic [3:0] r;
    hh = h == 0 ? 1 : h;
    nb = 4 * hh;
    blen = abort_at > 0 ? abort_at : nb;
    e = 0;
    for (int j = 1; j <= blen; j++) exp_a_q.push_back(p[(j - 1) / hh]);
    for (int j = hh; j <= nb; j += hh)
      if (!(abort_at > 0 && j >= abort_at) && force0 && !sel && p[j / hh - 1]) e++;
    exp_r_q.push_back({3'(e), abort_at == 0 && e == 0});
    @(negedge clk);
    pattern = p;
    hold_cycles = 8'(h);
    start = 1'b1;
    for (int j = 1; j <= blen + 2; j++) begin
      @(negedge clk);
      start = midstart && j == 2;
      if (start) begin
        pattern = ~p;
        hold_cycles = 8'd7;
      end
      if (j <= blen) begin
        check("busy", mb, 1);
        check("done_early", md, 0);
        check("drive_a", ma, exp_a_q.pop_front());
      end else if (j == blen + 1) begin
        r = exp_r_q.pop_front();
        check("done", md, 1);
        check("busy_done", mb, 0);
        check("drive_a_done", ma, 0);
        check("err_cnt", me, r[3:1]);
        check("pass", mp, r[0]);
      end else begin
        check("done_after", md, 0);
        check("busy_after", mb, 0);
        check("err_hold", me, r[3:1]);
        check("pass_hold", mp, r[0]);
      end
      abort = j == abort_at;
    end
  endtask
  initial begin
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("idle");
    run(4'b0101, 3, 0, 1'b0);
    force0 = 1'b1;
    run(4'b1011, 2, 0, 1'b0);
    run(4'b1111, 1, 4, 1'b0);
    force0 = 1'b0;
    run(4'b0011, 0, 0, 1'b0);
    run(4'b0110, 3, 5, 1'b1);
    sel = 1'b1;
    run(4'b1100, 5, 0, 1'b0);
    @(negedge clk);
    pattern = 4'b1100;
    hold_cycles = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_drive_a", ma, 1);
    check("mid_busy", mb, 1);
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      check("no_done_after_reset", md, 0);
      check("idle_after_reset", mb, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
